// File: rtl/caliptra_fpga_sync_apb_master.sv
//------------------------------------------------------------------------------
// caliptra_fpga_sync_apb_master
//
// Register-driven APB master for the FPGA sync wrapper. It lives in the
// aclk_gated domain and drives caliptra_top's APB slave port. It replaces the
// old scheme, where register bits drove the APB signals directly.
//
// A host-side register block hands over one request at a time through a
// valid/ready handshake. This block then runs a compliant SETUP/ACCESS
// sequence and returns the sampled PRDATA/PSLVERR through a second valid/ready
// handshake. A 16-bit counter of completed responses lets the host track
// progress without watching the bus.
//
// Optional build feature:
//   CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN - when defined, ACCESS is aborted after
//   TIMEOUT_CYCLES cycles without PREADY. The abort reports
//   resp_timeout=1, resp_slverr=1 and resp_rdata=0. When the macro is not
//   defined, ACCESS waits for PREADY indefinitely and resp_timeout is tied to 0.
//
// Parameters:
//   ADDR_W          APB address width
//   DATA_W          PWDATA/PRDATA width
//   PAUSER_W        PAUSER width
//   TIMEOUT_CYCLES  max ACCESS cycles without PREADY (timeout build only, >=1)
//
// Ports:
//   aclk_gated                 gated core clock; only granted cycles advance state
//   rstn                       asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_write                  1 = write, 0 = read
//   req_addr / req_wdata       target address / write data
//   req_pprot / req_pauser     APB attributes for the transfer
//   resp_valid / resp_ready    response handshake; response held until taken
//   resp_rdata                 PRDATA sample (0 for writes and timeouts)
//   resp_slverr                PSLVERR sample, or 1 on timeout
//   resp_timeout               transfer aborted by the ACCESS timeout
//   txn_count                  completed responses, wraps 0xFFFF -> 0
//   psel/penable/pwrite        APB control (registered)
//   paddr/pwdata/pprot/pauser  APB payload, stable from SETUP to completion
//   pready/pslverr/prdata      APB completion inputs from the slave
//------------------------------------------------------------------------------
module caliptra_fpga_sync_apb_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int PAUSER_W       = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                aclk_gated,
   input  logic                rstn,

   // Request side
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [2:0]          req_pprot,
   input  logic [PAUSER_W-1:0] req_pauser,

   // Response side
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_slverr,
   output logic                resp_timeout,
   output logic [15:0]         txn_count,

   // APB master port
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [2:0]          pprot,
   output logic [PAUSER_W-1:0] pauser,
   input  logic                pready,
   input  logic                pslverr,
   input  logic [DATA_W-1:0]   prdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t state;

`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
   // The counter is kept at least 10 bits wide, so the default depth and
   // small test depths share one structure.
   localparam int              TO_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int              TO_W     = (TO_RAW_W > 10) ? TO_RAW_W : 10;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   // Number of ACCESS cycles that have already passed without PREADY.
   logic [TO_W-1:0] to_cnt;
`else
   // The timeout depth only matters in the timeout build.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign resp_timeout       = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Main FSM. Every output is a register. The asynchronous reset drops
   // psel/penable at once, even in the middle of a transfer, and discards any
   // pending response.
   //---------------------------------------------------------------------------
   always_ff @(posedge aclk_gated or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_slverr  <= 1'b0;
         txn_count    <= '0;
         psel         <= 1'b0;
         penable      <= 1'b0;
         pwrite       <= 1'b0;
         paddr        <= '0;
         pwdata       <= '0;
         pprot        <= '0;
         pauser       <= '0;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
         resp_timeout <= 1'b0;
         to_cnt       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // req_ready comes up one cycle after reset release, and one
               // cycle after each response handshake.
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  // Capture the whole request now. Later changes on req_*
                  // cannot disturb the transfer that is in flight.
                  pwrite    <= req_write;
                  paddr     <= req_addr;
                  pwdata    <= req_wdata;
                  pprot     <= req_pprot;
                  pauser    <= req_pauser;
                  psel      <= 1'b1;
                  penable   <= 1'b0;
                  req_ready <= 1'b0;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               // SETUP always lasts exactly one cycle.
               penable <= 1'b1;
               state   <= S_ACCESS;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
               to_cnt  <= '0;
`endif
            end

            S_ACCESS: begin
               if (pready) begin
                  // A PREADY that arrives in the expiry cycle still completes
                  // the transfer normally.
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  resp_rdata  <= pwrite ? '0 : prdata;
                  resp_slverr <= pslverr;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
                  resp_timeout <= 1'b0;
`endif
                  resp_valid  <= 1'b1;
                  state       <= S_RESP;
               end
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  // This is ACCESS cycle TIMEOUT_CYCLES with no PREADY.
                  // Abort the transfer and report it as a timed-out error.
                  psel         <= 1'b0;
                  penable      <= 1'b0;
                  resp_rdata   <= '0;
                  resp_slverr  <= 1'b1;
                  resp_timeout <= 1'b1;
                  resp_valid   <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end

            S_RESP: begin
               // Hold the response until the consumer takes it. A request that
               // is already waiting is accepted only after the FSM is back in
               // IDLE.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  txn_count  <= txn_count + 16'd1;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_caliptra_fpga_sync_apb_master.sv
//------------------------------------------------------------------------------
// Self-checking bench for caliptra_fpga_sync_apb_master.
//
// A driver issues requests. For each request it also decides how the APB slave
// will answer: the number of wait states, PRDATA and PSLVERR. From that choice
// a reference model derives the expected response and the cycle in which it
// must appear, and pushes this into a scoreboard queue. An APB slave process
// checks the bus phases and attributes. A monitor process pops and compares
// each response as it is presented.
//------------------------------------------------------------------------------
module tb_caliptra_fpga_sync_apb_master;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int PAUSER_W = 32;
   localparam int TC       = 8;
`ifdef CALIPTRA_FPGA_SYNC_APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                aclk_gated = 1'b0;
   logic                rstn;
   logic                req_valid, req_ready, req_write;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic [2:0]          req_pprot;
   logic [PAUSER_W-1:0] req_pauser;
   logic                resp_valid, resp_ready, resp_slverr, resp_timeout;
   logic [DATA_W-1:0]   resp_rdata;
   logic [15:0]         txn_count;
   logic                psel, penable, pwrite, pready, pslverr;
   logic [ADDR_W-1:0]   paddr;
   logic [DATA_W-1:0]   pwdata, prdata;
   logic [2:0]          pprot;
   logic [PAUSER_W-1:0] pauser;

   caliptra_fpga_sync_apb_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAUSER_W(PAUSER_W), .TIMEOUT_CYCLES(TC)
   ) dut (
      .aclk_gated(aclk_gated), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pprot(req_pprot),
      .req_pauser(req_pauser),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_slverr(resp_slverr), .resp_timeout(resp_timeout), .txn_count(txn_count),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pprot(pprot), .pauser(pauser),
      .pready(pready), .pslverr(pslverr), .prdata(prdata)
   );

   always #5 aclk_gated = ~aclk_gated;

   int cyc = 0;
   always @(posedge aclk_gated) cyc <= cyc + 1;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  pprot;
      logic [31:0] pauser;
      int          w;        // wait states before PREADY
      logic [31:0] prdata;
      logic        pslverr;
      int          hold;     // cycles the consumer stalls resp_ready
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      logic        timeout;
      int          resp_cyc;
      int          hold;
   } exp_t;

   txn_t slv_q[$];
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=absent required=present cyc=%0d", name, cyc);
   endtask

   // Reference model. The slave's chosen answer and the accept cycle fix the
   // response. PREADY after w wait states is sampled at accept+2+w. A timeout
   // fires at accept+1+TC, once TC ACCESS cycles have passed with no PREADY.
   function automatic exp_t model(input txn_t t, input int acc);
      exp_t e;
      bit   to;
      to         = TO_EN && (t.w >= TC);
      e.timeout  = to;
      e.slverr   = to ? 1'b1 : t.pslverr;
      e.rdata    = (to || t.write) ? 32'h0 : t.prdata;
      e.resp_cyc = acc + (to ? (1 + TC) : (2 + t.w));
      e.hold     = t.hold;
      return e;
   endfunction

   function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input int w, input logic [31:0] rd, input logic se, input int hold);
      txn_t t;
      t.write = wr;  t.addr = a;  t.wdata = d;  t.pprot = 3'($urandom);
      t.pauser = $urandom;  t.w = w;  t.prdata = rd;  t.pslverr = se;  t.hold = hold;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      int w, h;
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3));
      h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      return mk(1'($urandom), $urandom, $urandom, w, $urandom, ($urandom_range(0, 3) == 0), h);
   endfunction

   // Driver: call at a negedge. It presents the request, waits for
   // acceptance, records the expectation, then scrambles req_*.
   task automatic issue(input txn_t t);
      int n;
      n = 0;
      req_write = t.write;  req_addr = t.addr;  req_wdata = t.wdata;
      req_pprot = t.pprot;  req_pauser = t.pauser;  req_valid = 1'b1;
      while (!req_ready && n <= 500) begin
         @(negedge aclk_gated);
         n++;
      end
      if (!req_ready) begin
         fail("req_accept_timeout");
         req_valid = 1'b0;
      end else begin
         slv_q.push_back(t);
         exp_q.push_back(model(t, cyc + 1));
         @(negedge aclk_gated);
         req_valid  = 1'b0;
         req_write  = 1'($urandom);
         req_addr   = $urandom;
         req_wdata  = $urandom;
         req_pprot  = 3'($urandom);
         req_pauser = $urandom;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || slv_q.size() != 0 || resp_valid || psel) && n < 4000) begin
         @(negedge aclk_gated);
         n++;
      end
      if (n >= 4000) fail("drain_timeout");
      repeat (2) @(negedge aclk_gated);
   endtask

   task automatic chk_attr(input txn_t t);
      chk("paddr", paddr, t.addr);
      chk("pwdata", pwdata, t.wdata);
      chk("pwrite_pprot", {pwrite, pprot}, {t.write, t.pprot});
      chk("pauser", pauser, t.pauser);
   endtask

   // APB slave model. It drives PREADY (and random noise outside ACCESS) and
   // checks the phase sequence and payload stability.
   initial begin
      txn_t st;
      pready = 1'b0;  pslverr = 1'b0;  prdata = '0;
      forever begin
         @(negedge aclk_gated);
         if (rstn && psel && !penable) begin
            if (slv_q.size() == 0) begin
               fail("unexpected_setup");
            end else begin
               st = slv_q.pop_front();
               chk_attr(st);
               @(negedge aclk_gated);
               for (int i = 0; rstn; i++) begin
                  chk("access_phase", {psel, penable}, 2'b11);
                  chk_attr(st);
                  if (i == st.w) begin
                     pready = 1'b1;  prdata = st.prdata;  pslverr = st.pslverr;
                  end else begin
                     pready = 1'b0;  prdata = $urandom;  pslverr = 1'($urandom);
                  end
                  @(negedge aclk_gated);
                  pready = 1'b0;
                  if (!rstn) break;
                  if (i == st.w) begin
                     chk("psel_release", {psel, penable}, 2'b00);
                     break;
                  end
                  if (!psel) begin
                     chk("abort_point", i + 1, (TO_EN && st.w >= TC) ? TC : st.w + 1);
                     chk("abort_penable", penable, 1'b0);
                     break;
                  end
                  if (i >= 200) begin
                     fail("access_stuck");
                     break;
                  end
               end
            end
         end else begin
            pready  = 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
         end
      end
   end

   // Response monitor / scoreboard.
   initial begin
      exp_t cur;
      int   hold, exp_cnt;
      bit   seen, hs;
      resp_ready = 1'b0;  seen = 1'b0;  hs = 1'b0;  hold = 0;  exp_cnt = 0;
      forever begin
         @(negedge aclk_gated);
         if (!rstn) begin
            seen = 1'b0;  hs = 1'b0;  hold = 0;  exp_cnt = 0;  resp_ready = 1'b0;
         end else begin
            if (hs) begin
               exp_cnt++;
               chk("txn_count", txn_count, 16'(exp_cnt));
               chk("resp_valid_clear", resp_valid, 1'b0);
               seen = 1'b0;
               hs   = 1'b0;
            end
            if (resp_valid || psel) chk("req_ready_busy", req_ready, 1'b0);
            if (resp_valid) begin
               if (!seen) begin
                  if (exp_q.size() == 0) begin
                     fail("unexpected_response");
                     cur.rdata = resp_rdata;  cur.slverr = resp_slverr;
                     cur.timeout = resp_timeout;  cur.hold = 0;
                  end else begin
                     cur = exp_q.pop_front();
                     chk("resp_latency", cyc, cur.resp_cyc);
                     chk("resp_rdata", resp_rdata, cur.rdata);
                     chk("resp_slverr", resp_slverr, cur.slverr);
                     chk("resp_timeout", resp_timeout, cur.timeout);
                  end
                  hold = cur.hold;
                  seen = 1'b1;
               end else begin
                  chk("resp_held", {resp_rdata, resp_slverr, resp_timeout},
                      {cur.rdata, cur.slverr, cur.timeout});
               end
               if (hold > 0) begin
                  resp_ready = 1'b0;
                  hold--;
               end else begin
                  resp_ready = ($urandom_range(0, 3) != 0);
               end
               hs = resp_ready;
            end else begin
               if (seen) begin
                  fail("resp_dropped");
                  seen = 1'b0;
               end
               resp_ready = 1'($urandom);
            end
         end
      end
   end

   // Main sequence.
   initial begin
      rstn = 1'b0;  req_valid = 1'b0;  req_write = 1'b0;  req_addr = '0;
      req_wdata = '0;  req_pprot = '0;  req_pauser = '0;
      repeat (3) @(negedge aclk_gated);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_apb_ctl", {psel, penable, pwrite}, 3'b000);
      chk("rst_resp", {resp_valid, resp_slverr, resp_timeout}, 3'b000);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_txn_count", txn_count, 16'h0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      rstn = 1'b1;
      chk("rel_req_ready_low", req_ready, 1'b0);
      @(negedge aclk_gated);
      chk("rel_req_ready_high", req_ready, 1'b1);

      // Directed cases
      issue(mk(1'b1, 32'h3002_0000, 32'hA5A5_5A5A, 0, 32'h0, 1'b0, 0));
      issue(mk(1'b0, 32'h3003_0000, 32'h0, 5, 32'h1234_5678, 1'b0, 0));
      issue(mk(1'b0, 32'h3003_0004, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 0));
      issue(mk(1'b0, 32'h3003_0008, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 10));
      issue(mk(1'b1, 32'h3003_000C, 32'h5555_AAAA, 2, 32'h0, 1'b0, 0));
      issue(mk(1'b0, 32'h3004_0000, 32'h0, 120, 32'hCAFE_0001, 1'b0, 0));
      issue(mk(1'b0, 32'h3004_0004, 32'h0, TC - 1, 32'hCAFE_0002, 1'b1, 0));
      issue(mk(1'b0, 32'h3004_0008, 32'h0, TC, 32'hCAFE_0003, 1'b0, 0));
      wait_idle();

      // Asynchronous reset in the middle of ACCESS
      issue(mk(1'b0, 32'h3005_0000, 32'h0, 60, 32'h0, 1'b0, 0));
      repeat (4) @(negedge aclk_gated);
      chk("pre_reset_access", {psel, penable}, 2'b11);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_apb", {psel, penable}, 2'b00);
      chk("async_rst_resp", resp_valid, 1'b0);
      chk("async_rst_count", txn_count, 16'h0);
      exp_q.delete();
      slv_q.delete();
      repeat (2) @(negedge aclk_gated);
      rstn = 1'b1;
      chk("rel2_req_ready_low", req_ready, 1'b0);
      @(negedge aclk_gated);
      chk("rel2_req_ready_high", req_ready, 1'b1);
      issue(mk(1'b0, 32'h3005_0004, 32'h0, 2, 32'h7777_1111, 1'b0, 0));
      wait_idle();

      // Randomised traffic
      for (int n = 0; n < 120; n++) begin
         issue(rnd_txn());
         repeat ($urandom_range(0, 2)) @(negedge aclk_gated);
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
      $fatal(1, "simulation did not finish");
   end

endmodule
